// File: rtl/wordle_pkg.sv
// Shared constants for the Wordle scorer: tile colors, FSM states, size defaults.
package wordle_pkg;

  localparam int DEF_ROWS     = 6;
  localparam int DEF_COLS     = 5;
  localparam int DEF_LETTER_W = 8;

  // Tile colors as {R,G,B}
  localparam logic [2:0] BLANK  = 3'b000;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b110;
  localparam logic [2:0] ABSENT = 3'b111;

  typedef enum logic [1:0] {IDLE, MARK, SCAN, COMMIT} state_t;

endpackage

// File: rtl/wordle_tile_regfile.sv
// ROWS x COLS tile-color storage: one row-wide write port, global clear,
// registered single read port (old data on a same-edge read/write).
module wordle_tile_regfile
  import wordle_pkg::*;
#(
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [2:0]        wr_row,
  input  logic [COLS*3-1:0] wr_data,
  input  logic [2:0]        rd_row,
  input  logic [2:0]        rd_col,
  output logic [2:0]        rd_color
);

  logic [2:0] tile [ROWS][COLS];

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          tile[r][c] <= BLANK;
      rd_color <= BLANK;
    end else begin
      // Clear takes priority over a coincident row write.
      if (clear) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            tile[r][c] <= BLANK;
      end else if (wr_en && int'(wr_row) < ROWS) begin
        for (int c = 0; c < COLS; c++)
          tile[wr_row][c] <= wr_data[(COLS-1-c)*3 +: 3];
      end
      if (int'(rd_row) < ROWS && int'(rd_col) < COLS)
        rd_color <= tile[rd_row][rd_col];
      else
        rd_color <= BLANK;
    end
  end

endmodule

// File: rtl/wordle_guess_scorer.sv
// Sequential Wordle scorer: MARK greens, SCAN one column per cycle for yellows,
// COMMIT the row. WORDLE_SCORE_DUPLICATES_EN selects duplicate-aware scoring.
module wordle_guess_scorer
  import wordle_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int LETTER_W = DEF_LETTER_W
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     guess_valid,
  output logic                     guess_ready,
  input  logic [COLS*LETTER_W-1:0] guess,
  input  logic [COLS*LETTER_W-1:0] target,
  input  logic [2:0]               row_sel,
  input  logic                     clear,
  input  logic [2:0]               rd_row,
  input  logic [2:0]               rd_col,
  output logic [2:0]               rd_color,
  output logic                     done,
  output logic                     win
);

`ifdef WORDLE_SCORE_DUPLICATES_EN
  localparam bit DUP_EN = 1'b1;
`else
  localparam bit DUP_EN = 1'b0;
`endif

  state_t                  state;
  logic [COLS*LETTER_W-1:0] guess_reg, target_reg;
  logic [2:0]              row_reg, scan_idx, hit_idx;
  logic [COLS-1:0]         used;
  logic [2:0]              color [COLS];
  logic [LETTER_W-1:0]     g_l [COLS];
  logic [LETTER_W-1:0]     t_l [COLS];
  logic [COLS*3-1:0]       wr_data;
  logic                    hit, all_green;

  for (genvar gi = 0; gi < COLS; gi++) begin : g_unpack
    assign g_l[gi] = guess_reg[(COLS-1-gi)*LETTER_W +: LETTER_W];
    assign t_l[gi] = target_reg[(COLS-1-gi)*LETTER_W +: LETTER_W];
    assign wr_data[(COLS-1-gi)*3 +: 3] = color[gi];
  end

  // Descending sweep leaves the lowest eligible target position in hit_idx.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int j = COLS-1; j >= 0; j--) begin
      if (t_l[j] == g_l[scan_idx] && (!DUP_EN || !used[j])) begin
        hit     = 1'b1;
        hit_idx = 3'(j);
      end
    end
  end

  always_comb begin
    all_green = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (color[c] != GREEN) all_green = 1'b0;
  end

  assign guess_ready = (state == IDLE);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      guess_reg  <= '0;
      target_reg <= '0;
      row_reg    <= '0;
      scan_idx   <= '0;
      used       <= '0;
      for (int c = 0; c < COLS; c++) color[c] <= BLANK;
      done       <= 1'b0;
      win        <= 1'b0;
    end else begin
      done <= 1'b0;
      win  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (guess_valid) begin
            guess_reg  <= guess;
            target_reg <= target;
            row_reg    <= row_sel;
            state      <= MARK;
          end
        end
        MARK: begin
          for (int c = 0; c < COLS; c++) begin
            if (g_l[c] == t_l[c]) begin
              color[c] <= GREEN;
              used[c]  <= 1'b1;
            end else begin
              color[c] <= ABSENT;
              used[c]  <= 1'b0;
            end
          end
          scan_idx <= '0;
          state    <= SCAN;
        end
        SCAN: begin
          if (color[scan_idx] != GREEN && hit) begin
            color[scan_idx] <= YELLOW;
            used[hit_idx]   <= 1'b1;
          end
          if (scan_idx == 3'(COLS-1)) state <= COMMIT;
          else scan_idx <= scan_idx + 3'd1;
        end
        COMMIT: begin
          done  <= 1'b1;
          win   <= all_green;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  wordle_tile_regfile #(.ROWS(ROWS), .COLS(COLS)) u_tiles (
    .Clk      (Clk),
    .reset    (reset),
    .clear    (clear),
    .wr_en    (state == COMMIT),
    .wr_row   (row_reg),
    .wr_data  (wr_data),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_color (rd_color)
  );

endmodule
